// File: rtl/trace_buffer_reader.sv
// Drain side of the trace RAM: follows the capture write pointer over RAM port B and streams
// stored words out on a valid/ready link. Define TRACE_RD_CLEAR_EN for clear-on-read.
module trace_buffer_reader #(
  parameter int unsigned wordCount = 64,
  parameter int unsigned wordWidth = 8,
  localparam int unsigned AW = $clog2(wordCount)
) (
  input  logic                 io_clk,
  input  logic                 io_reset,
  input  logic [AW:0]          io_wrPtr,
  input  logic                 io_flush,
  output logic [AW-1:0]        io_adr_b,
  output logic                 io_wr_b,
  output logic [wordWidth-1:0] io_wrdata_b,
  input  logic [wordWidth-1:0] io_rddata_b,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [wordWidth-1:0] io_out_payload,
  output logic [AW:0]          io_level,
  output logic                 io_empty,
  output logic                 io_overrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  // wordCount expressed in pointer width (lap bit set, address bits clear)
  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

  state_e               state_q, state_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 valid_q, valid_d;
  logic [wordWidth-1:0] payload_q, payload_d;
  logic                 overrun_q, overrun_d;
  logic [AW:0]          level;

  assign level = io_wrPtr - rd_ptr_q;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    overrun_d = overrun_q;
    if (io_flush) begin
      rd_ptr_d  = io_wrPtr;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      state_d   = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (level > Depth) begin
            overrun_d = 1'b1;
            rd_ptr_d  = io_wrPtr - Depth;
          end else if (level != '0) begin
            state_d = StFetch;
          end
        end
        StFetch: begin
          payload_d = io_rddata_b;
          valid_d   = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          state_d   = StHold;
        end
        StHold: begin
          if (io_out_ready) begin
            valid_d = 1'b0;
            // a lapped pointer goes back through IDLE so the resync happens there
            state_d = ((level != '0) && (level <= Depth)) ? StFetch : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state_q   <= StIdle;
      rd_ptr_q  <= '0;
      valid_q   <= 1'b0;
      payload_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      overrun_q <= overrun_d;
    end
  end

  assign io_adr_b       = rd_ptr_q[AW-1:0];
  assign io_out_valid   = valid_q;
  assign io_out_payload = payload_q;
  assign io_level       = level;
  assign io_empty       = (level == '0);
  assign io_overrun     = overrun_q;
  assign io_wrdata_b    = '0;

`ifdef TRACE_RD_CLEAR_EN
  // zero the slot in the same cycle its word is captured
  assign io_wr_b = (state_q == StFetch) && !io_flush && !io_reset;
`else
  assign io_wr_b = 1'b0;
`endif

endmodule

// File: tb/tb_trace_buffer_reader.sv
// Self-checking bench for trace_buffer_reader: directed scenarios plus a randomized stream
// checked against an in-order queue of written words.
module tb_trace_buffer_reader;

  localparam int unsigned WC = 64;
  localparam int unsigned WW = 8;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   wr_ptr;
  logic          flush;
  logic [AW-1:0] adr_b;
  logic          wr_b;
  logic [WW-1:0] wrdata_b;
  logic [WW-1:0] rddata_b;
  logic          valid;
  logic          ready;
  logic [WW-1:0] payload;
  logic [AW:0]   level;
  logic          empty;
  logic          overrun;

  logic [WW-1:0] mem [WC];
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [WW-1:0] a_data;

  logic [WW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wrb_cnt = 0;
  int wrb_bad = 0;

  always #5 clk = ~clk;

  trace_buffer_reader #(.wordCount(WC), .wordWidth(WW)) dut (
    .io_clk(clk), .io_reset(reset), .io_wrPtr(wr_ptr), .io_flush(flush),
    .io_adr_b(adr_b), .io_wr_b(wr_b), .io_wrdata_b(wrdata_b), .io_rddata_b(rddata_b),
    .io_out_valid(valid), .io_out_ready(ready), .io_out_payload(payload),
    .io_level(level), .io_empty(empty), .io_overrun(overrun)
  );

  // Dual-port RAM model: port A from the bench, port B from the DUT, read-first.
  always @(posedge clk) begin
    rddata_b <= mem[adr_b];
    if (a_we) mem[a_addr] <= a_data;
    if (wr_b) mem[adr_b] <= wrdata_b;
  end

  always @(negedge clk) begin
    if (wr_b) begin
      wrb_cnt++;
      if (wrdata_b !== '0) wrb_bad++;
    end
  end

  // Called at a negedge; the word lands at the following posedge.
  task automatic preload(input int slot, input logic [WW-1:0] v);
    a_we = 1'b1;
    a_addr = slot[AW-1:0];
    a_data = v;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic flush_to(input int p);
    wr_ptr = p[AW:0];
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain(input string name, input int n, input int budget);
    int got = 0;
    ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got payload %0h, required no word", name, payload);
        end else begin
          if (payload !== exp_q[0]) begin
            errors++;
            $display("FAIL %s_data[%0d]: got %0h, required %0h", name, got, payload, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words, required %0d", name, got, n);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int c = 0; c < budget && !valid; c++) @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got valid %b, required 1", name, valid);
    end
  endtask

  task automatic test_reset();
    wr_ptr = '0; flush = 1'b0; ready = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({valid, empty, overrun, wr_b} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags: got v/e/o/w %b%b%b%b, required 0100", valid, empty, overrun, wr_b);
    end
    checks++;
    if (level !== '0 || adr_b !== '0 || payload !== '0 || wrdata_b !== '0) begin
      errors++;
      $display("FAIL reset_values: got level %0d adr %0d payload %0h wrdata %0h, required 0",
               level, adr_b, payload, wrdata_b);
    end
  endtask

  task automatic test_basic();
    preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    ready = 1'b1;
    wr_ptr = 7'd3;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1: got valid %b, required 0", valid);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || payload !== 8'h11) begin
      errors++;
      $display("FAIL basic_latency2: got valid %b payload %0h, required 1 11", valid, payload);
    end
    drain("basic", 3, 20);
    checks++;
    if (empty !== 1'b1 || level !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: got empty %b level %0d valid %b, required 1 0 0",
               empty, level, valid);
    end
  endtask

  task automatic test_hold();
    preload(3, 8'h5A);
    ready = 1'b0;
    wr_ptr = 7'd4;
    wait_valid("hold", 10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || payload !== 8'h5A || adr_b !== 6'd4) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid %b payload %0h adr %0d, required 1 5a 4",
                 c, valid, payload, adr_b);
      end
    end
    exp_q.push_back(8'h5A);
    drain("hold", 1, 5);
    checks++;
    if (valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL hold_release: got valid %b level %0d, required 0 0", valid, level);
    end
  endtask

  task automatic test_wrap();
    logic [WW-1:0] v;
    flush_to(62);
    checks++;
    if (adr_b !== 6'd62 || level !== '0) begin
      errors++;
      $display("FAIL wrap_flush: got adr %0d level %0d, required 62 0", adr_b, level);
    end
    for (int i = 62; i < 66; i++) begin
      v = 8'(i * 7 + 1);
      preload(i % 64, v);
      exp_q.push_back(v);
    end
    ready = 1'b0;
    wr_ptr = 7'd66;
    #1;
    checks++;
    if (level !== 7'd4) begin
      errors++;
      $display("FAIL wrap_level: got %0d, required 4", level);
    end
    @(negedge clk);
    drain("wrap", 4, 30);
    checks++;
    if (level !== '0 || empty !== 1'b1 || adr_b !== 6'd2) begin
      errors++;
      $display("FAIL wrap_end: got level %0d empty %b adr %0d, required 0 1 2", level, empty, adr_b);
    end
  endtask

  task automatic test_overrun();
    logic [WW-1:0] v;
    flush_to(0);
    for (int i = 6; i < 70; i++) begin
      v = 8'($urandom);
      preload(i % 64, v);
      exp_q.push_back(v);
    end
    ready = 1'b0;
    wr_ptr = 7'd70;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || adr_b !== 6'd6 || level !== 7'd64 || valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_detect: got ovr %b adr %0d level %0d valid %b, required 1 6 64 0",
               overrun, adr_b, level, valid);
    end
    drain("overrun", 64, 300);
    checks++;
    if (overrun !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got ovr %b empty %b, required 1 1", overrun, empty);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (overrun !== 1'b0 || valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL overrun_flush: got ovr %b valid %b level %0d, required 0 0 0",
               overrun, valid, level);
    end
  endtask

  task automatic test_flush_hold();
    preload(6, 8'hC3); preload(7, 8'h3C);
    ready = 1'b0;
    wr_ptr = 7'd72;
    wait_valid("flushhold", 10);
    flush = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (valid !== 1'b0 || level !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL flushhold_drop: got valid %b level %0d ovr %b, required 0 0 0",
               valid, level, overrun);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL flushhold_quiet: got valid %b, required 0", valid);
    end
    ready = 1'b0;
  endtask

  task automatic test_clear();
    int base;
    flush_to(68);
    preload(4, 8'hA1); preload(5, 8'hB2);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    base = wrb_cnt;
    wr_ptr = 7'd70;
    drain("clear", 2, 20);
    @(negedge clk);
    #1;
`ifdef TRACE_RD_CLEAR_EN
    checks++;
    if (wrb_cnt - base != 2 || mem[4] !== '0 || mem[5] !== '0) begin
      errors++;
      $display("FAIL clear_on_read: got %0d pulses RAM4 %0h RAM5 %0h, required 2 0 0",
               wrb_cnt - base, mem[4], mem[5]);
    end
`else
    checks++;
    if (wrb_cnt - base != 0 || mem[4] !== 8'hA1 || mem[5] !== 8'hB2) begin
      errors++;
      $display("FAIL no_clear: got %0d pulses RAM4 %0h RAM5 %0h, required 0 a1 b2",
               wrb_cnt - base, mem[4], mem[5]);
    end
`endif
    checks++;
    if (wrb_bad != 0) begin
      errors++;
      $display("FAIL clear_wrdata: got %0d nonzero writes, required 0", wrb_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int wr_abs;
    int hs;
    logic pend = 1'b0;
    logic [WW-1:0] v;
    exp_q.delete();
    flush_to(int'(wr_ptr));
    wr_abs = int'(wr_ptr);
    hs = wr_abs;
    for (int c = 0; c < 1500; c++) begin
      if (pend) begin
        wr_ptr = wr_ptr + 1'b1;
        pend = 1'b0;
      end
      if (valid) begin
        checks++;
        if (exp_q.size() == 0 || payload !== exp_q[0]) begin
          errors++;
          $display("FAIL random_data[%0d]: got %0h, required %0h", hs,
                   payload, (exp_q.size() == 0) ? 8'h00 : exp_q[0]);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      if (valid && ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        hs++;
      end
      if ((wr_abs - hs < 64) && ($urandom_range(0, 1) == 1)) begin
        v = 8'($urandom);
        a_we = 1'b1;
        a_addr = 6'(wr_abs % 64);
        a_data = v;
        exp_q.push_back(v);
        wr_abs++;
        pend = 1'b1;
      end else begin
        a_we = 1'b0;
      end
      @(negedge clk);
    end
    a_we = 1'b0;
    if (pend) wr_ptr = wr_ptr + 1'b1;
    drain("random_tail", exp_q.size(), 400);
    checks++;
    if (empty !== 1'b1 || level !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL random_end: got empty %b level %0d ovr %b, required 1 0 0",
               empty, level, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_overrun();
    test_flush_hold();
    test_clear();
    test_random();
`ifndef TRACE_RD_CLEAR_EN
    checks++;
    if (wrb_cnt != 0) begin
      errors++;
      $display("FAIL wr_b_idle: got %0d pulses, required 0", wrb_cnt);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
